// File: rtl/pixel_pkg.sv
// Shared definitions for the frame-buffer store path: window tag, screen
// geometry and the pixel request record carried through the queue.
package pixel_pkg;

  localparam logic [9:0] FB_BASE_TAG = 10'h041;
  localparam logic [9:0] FB_WIDTH    = 10'd800;
  localparam logic [9:0] FB_HEIGHT   = 10'd600;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } pixel_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers. Full/empty/level are derived
// from the pointer flops only, so status never combinationally follows
// this cycle's push/pop requests.
module sync_fifo #(
  parameter int unsigned WIDTH = 44,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for storage and pointers; guarded so misuse cannot corrupt state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // State registers; storage is cleared so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/pixel_store_queue.sv
// Frame-buffer write path: snoops CPU stores to the 0x1040_0000 window,
// decodes (x, y, rgb), queues them and drains over valid/ready.
// Optional feature macro: PIXEL_BOUNDS_CHECK_EN (drop off-screen pixels
// and count them in drop_count; otherwise every hit is queued).
module pixel_store_queue
  import pixel_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_valid,
  input  logic [31:0]             cpu_addr,
  input  logic [3:0]              cpu_we,
  input  logic [31:0]             cpu_din,
  output logic                    cpu_stall,
  output logic                    fb_valid,
  input  logic                    fb_ready,
  output logic [9:0]              fb_x,
  output logic [9:0]              fb_y,
  output logic [23:0]             fb_rgb,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [CNT_W-1:0]        drop_count
);

  logic       hit;
  logic       in_range;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  pixel_req_t req;
  pixel_req_t head;
  logic       unused_bits;

  assign unused_bits = ^{cpu_addr[1:0], cpu_din[31:24]};

  assign hit = cpu_valid && (cpu_we != 4'b0000) && (cpu_addr[31:22] == FB_BASE_TAG);

  assign req.x   = cpu_addr[11:2];
  assign req.y   = cpu_addr[21:12];
  assign req.rgb = cpu_din[23:0];

`ifdef PIXEL_BOUNDS_CHECK_EN
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  assign in_range = (req.x < FB_WIDTH) && (req.y < FB_HEIGHT);

  // Saturating count of off-screen stores that were discarded
  always_comb begin
    drop_count_d = drop_count_q;
    if (hit && !in_range && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + CNT_W'(1);
    end
  end

  // Drop counter register
  always_ff @(posedge clk) begin
    if (!rst_n) drop_count_q <= '0;
    else        drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`else
  assign in_range   = 1'b1;
  assign drop_count = '0;
`endif

  // Full is registered state, so a pop this cycle never frees a slot for a
  // push in the same cycle; stall therefore depends only on cpu_* inputs.
  assign push      = hit && in_range && !full;
  assign cpu_stall = rst_n && hit && in_range && full;

  assign fb_valid = !empty;
  assign pop      = fb_valid && fb_ready;

  sync_fifo #(
    .WIDTH ($bits(pixel_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (req),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign fb_x   = head.x;
  assign fb_y   = head.y;
  assign fb_rgb = head.rgb;

endmodule
